// File: rtl/axi_ic_pkg.sv
// ---------------------------------------------------------------------------
// axi_ic_pkg : shared AXI interconnect widths and arbiter state encoding (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

package axi_ic_pkg;

  localparam int AXI_ADDR_W      = 32;
  localparam int AXI_MST_ID_W    = 5;
  localparam int AXI_BURST_W     = 2;
  localparam int AXI_LEN_W       = 3;
  localparam int AXI_SIZE_W      = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/fifo.sv
// ---------------------------------------------------------------------------
// fifo : synchronous FIFO with simultaneous push/pop honoured when full (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module fifo #(
  parameter int DATA_WIDTH = 1,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  empty,
  output logic                  full
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W:0]        count;
  logic                  do_pop;
  logic                  do_push;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign empty    = (count == '0);
  assign full     = (count == (PTR_W + 1)'(FIFO_DEPTH));
  assign do_pop   = pop & ~empty;
  // a pop in the same cycle frees the slot the push needs
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/sa_aw_arbiter.sv
// ---------------------------------------------------------------------------
// sa_aw_arbiter : round-robin AW arbiter for one slave port, W order + cap (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module sa_aw_arbiter
  import axi_ic_pkg::*;
#(
  parameter int MST_AMT           = 2,
  parameter int OUTSTANDING_AMT   = 8,
  parameter int OUTST_CTN_W       = $clog2(OUTSTANDING_AMT) + 1,
  parameter int ADDR_WIDTH        = AXI_ADDR_W,
  parameter int TRANS_MST_ID_W    = AXI_MST_ID_W,
  parameter int TRANS_BURST_W     = AXI_BURST_W,
  parameter int TRANS_DATA_LEN_W  = AXI_LEN_W,
  parameter int TRANS_DATA_SIZE_W = AXI_SIZE_W,
  parameter int MST_ID_W          = $clog2(MST_AMT),
  parameter int TRANS_SLV_ID_W    = TRANS_MST_ID_W + MST_ID_W
) (
  input  logic                                   ACLK_i,
  input  logic                                   ARESETn_i,
  input  logic [TRANS_MST_ID_W*MST_AMT-1:0]      dsp_AWID_i,
  input  logic [ADDR_WIDTH*MST_AMT-1:0]          dsp_AWADDR_i,
  input  logic [TRANS_BURST_W*MST_AMT-1:0]       dsp_AWBURST_i,
  input  logic [TRANS_DATA_LEN_W*MST_AMT-1:0]    dsp_AWLEN_i,
  input  logic [TRANS_DATA_SIZE_W*MST_AMT-1:0]   dsp_AWSIZE_i,
  input  logic [MST_AMT-1:0]                     dsp_AWVALID_i,
  output logic [MST_AMT-1:0]                     dsp_AWREADY_o,
  output logic [TRANS_SLV_ID_W-1:0]              s_AWID_o,
  output logic [ADDR_WIDTH-1:0]                  s_AWADDR_o,
  output logic [TRANS_BURST_W-1:0]               s_AWBURST_o,
  output logic [TRANS_DATA_LEN_W-1:0]            s_AWLEN_o,
  output logic [TRANS_DATA_SIZE_W-1:0]           s_AWSIZE_o,
  output logic                                   s_AWVALID_o,
  input  logic                                   s_AWREADY_i,
  input  logic                                   s_BVALID_i,
  input  logic                                   s_BREADY_i,
  input  logic                                   w_done_i,
  output logic [MST_ID_W-1:0]                    w_mst_id_o,
  output logic                                   w_mst_valid_o,
  output logic [OUTST_CTN_W-1:0]                 outst_ctn_o
);

  arb_state_e          state;
  logic [MST_ID_W-1:0] grant;
  logic [MST_ID_W-1:0] rr_ptr;
  logic [MST_ID_W-1:0] next_grant;
  logic [MST_ID_W:0]   cand_sum [MST_AMT];
  logic [MST_ID_W-1:0] cand     [MST_AMT];
  logic [MST_AMT-1:0]  rot_req;
  logic                aw_hs;
  logic                b_hs;
  logic                fifo_empty;
  logic                fifo_full;
  logic                blocked;

  // cand[i] is the master i places after rr_ptr; rot_req is the request vector rotated to match
  generate
    for (genvar i = 0; i < MST_AMT; i++) begin : g_rr
      assign cand_sum[i] = {1'b0, rr_ptr} + (MST_ID_W + 1)'(i);
      assign cand[i]     = (cand_sum[i] >= (MST_ID_W + 1)'(MST_AMT))
                         ? MST_ID_W'(cand_sum[i] - (MST_ID_W + 1)'(MST_AMT))
                         : cand_sum[i][MST_ID_W-1:0];
      assign rot_req[i]  = dsp_AWVALID_i[cand[i]];
    end
  endgenerate

  always_comb begin
    next_grant = cand[0];
    for (int i = MST_AMT - 1; i >= 0; i--) begin
      if (rot_req[i]) next_grant = cand[i];
    end
  end

  assign blocked = (outst_ctn_o == OUTST_CTN_W'(OUTSTANDING_AMT)) | fifo_full;
  assign aw_hs   = s_AWVALID_o & s_AWREADY_i;
  assign b_hs    = s_BVALID_i & s_BREADY_i;

  always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
    if (!ARESETn_i) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|dsp_AWVALID_i && !blocked) begin
            grant <= next_grant;
            state <= GRANT;
          end
        end
        GRANT: begin
          // grant stays locked until the slave accepts, regardless of AWVALID
          if (s_AWREADY_i) begin
            rr_ptr <= (grant == MST_ID_W'(MST_AMT - 1)) ? '0 : grant + 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign s_AWVALID_o = (state == GRANT);
  assign s_AWID_o    = {grant, dsp_AWID_i[int'(grant)*TRANS_MST_ID_W +: TRANS_MST_ID_W]};
  assign s_AWADDR_o  = dsp_AWADDR_i[int'(grant)*ADDR_WIDTH +: ADDR_WIDTH];
  assign s_AWBURST_o = dsp_AWBURST_i[int'(grant)*TRANS_BURST_W +: TRANS_BURST_W];
  assign s_AWLEN_o   = dsp_AWLEN_i[int'(grant)*TRANS_DATA_LEN_W +: TRANS_DATA_LEN_W];
  assign s_AWSIZE_o  = dsp_AWSIZE_i[int'(grant)*TRANS_DATA_SIZE_W +: TRANS_DATA_SIZE_W];

  always_comb begin
    dsp_AWREADY_o = '0;
    if (state == GRANT) dsp_AWREADY_o[grant] = s_AWREADY_i;
  end

  always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
    if (!ARESETn_i) begin
      outst_ctn_o <= '0;
    end else if (aw_hs && !b_hs && outst_ctn_o < OUTST_CTN_W'(OUTSTANDING_AMT)) begin
      outst_ctn_o <= outst_ctn_o + 1'b1;
    end else if (b_hs && !aw_hs && outst_ctn_o != '0) begin
      outst_ctn_o <= outst_ctn_o - 1'b1;
    end
  end

  fifo #(
    .DATA_WIDTH (MST_ID_W),
    .FIFO_DEPTH (OUTSTANDING_AMT)
  ) u_order_fifo (
    .clk       (ACLK_i),
    .rst_n     (ARESETn_i),
    .push      (aw_hs),
    .push_data (grant),
    .pop       (w_done_i),
    .pop_data  (w_mst_id_o),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign w_mst_valid_o = ~fifo_empty;

endmodule

`default_nettype wire

// File: tb/tb_sa_aw_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sa_aw_arbiter : directed scoreboard bench for sa_aw_arbiter (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sa_aw_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  awid;
  logic [63:0] awaddr;
  logic [3:0]  awburst;
  logic [5:0]  awlen;
  logic [5:0]  awsize;
  logic [1:0]  awvalid;
  logic [1:0]  awready;
  logic [5:0]  s_awid;
  logic [31:0] s_awaddr;
  logic [1:0]  s_awburst;
  logic [2:0]  s_awlen;
  logic [2:0]  s_awsize;
  logic        s_awvalid;
  logic        s_awready;
  logic        bvalid;
  logic        bready;
  logic        w_done;
  logic        w_mst_id;
  logic        w_mst_valid;
  logic [3:0]  outst;

  typedef struct {
    logic [5:0]  id;
    logic [31:0] addr;
    logic [2:0]  len;
  } aw_exp_t;

  aw_exp_t aw_q[$];
  logic    w_q[$];
  int      exp_ctn = 0;
  int      vectors = 0;
  int      miscompares = 0;

  always #5 clk = ~clk;

  sa_aw_arbiter dut (
    .ACLK_i        (clk),
    .ARESETn_i     (rst_n),
    .dsp_AWID_i    (awid),
    .dsp_AWADDR_i  (awaddr),
    .dsp_AWBURST_i (awburst),
    .dsp_AWLEN_i   (awlen),
    .dsp_AWSIZE_i  (awsize),
    .dsp_AWVALID_i (awvalid),
    .dsp_AWREADY_o (awready),
    .s_AWID_o      (s_awid),
    .s_AWADDR_o    (s_awaddr),
    .s_AWBURST_o   (s_awburst),
    .s_AWLEN_o     (s_awlen),
    .s_AWSIZE_o    (s_awsize),
    .s_AWVALID_o   (s_awvalid),
    .s_AWREADY_i   (s_awready),
    .s_BVALID_i    (bvalid),
    .s_BREADY_i    (bready),
    .w_done_i      (w_done),
    .w_mst_id_o    (w_mst_id),
    .w_mst_valid_o (w_mst_valid),
    .outst_ctn_o   (outst)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_m(input int m, input logic [4:0] id, input logic [31:0] addr);
    awid[m*5 +: 5]    = id;
    awaddr[m*32 +: 32] = addr;
  endtask

  task automatic expect_aw(input int m);
    aw_exp_t e;
    e.id   = {m[0], awid[m*5 +: 5]};
    e.addr = awaddr[m*32 +: 32];
    e.len  = awlen[m*3 +: 3];
    aw_q.push_back(e);
    w_q.push_back(m[0]);
  endtask

  // compare the handshake currently on the slave AW channel against the scoreboard head
  task automatic check_hs(input string tag);
    aw_exp_t e;
    if (aw_q.size() == 0) begin
      check({tag, " sb_depth"}, 64'(aw_q.size()), 64'd1);
    end else begin
      e = aw_q.pop_front();
      check({tag, " awid"}, 64'(s_awid), 64'(e.id));
      check({tag, " awaddr"}, 64'(s_awaddr), 64'(e.addr));
      check({tag, " awlen"}, 64'(s_awlen), 64'(e.len));
      exp_ctn++;
    end
  endtask

  task automatic wait_aw(input string tag, input int exp_lat);
    int cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(s_awvalid && s_awready) && cyc < 20);
    check({tag, " latency"}, 64'(cyc), 64'(exp_lat));
    if (s_awvalid && s_awready) check_hs(tag);
    else if (aw_q.size() != 0) begin
      void'(aw_q.pop_front());
      if (w_q.size() != 0) void'(w_q.pop_back());
    end
  endtask

  task automatic w_pop(input string tag, input logic with_b);
    check({tag, " wvalid"}, 64'(w_mst_valid), 64'd1);
    if (w_q.size() == 0) check({tag, " wq_depth"}, 64'(w_q.size()), 64'd1);
    else check({tag, " wid"}, 64'(w_mst_id), 64'(w_q.pop_front()));
    w_done = 1'b1;
    if (with_b) begin
      bvalid = 1'b1;
      bready = 1'b1;
      exp_ctn--;
    end
    @(negedge clk);
    w_done = 1'b0;
    bvalid = 1'b0;
    bready = 1'b0;
  endtask

  task automatic drain(input string tag);
    while (w_q.size() > 0) w_pop(tag, exp_ctn > 0);
    check({tag, " drained wvalid"}, 64'(w_mst_valid), 64'd0);
    check({tag, " drained outst"}, 64'(outst), 64'(exp_ctn));
  endtask

  initial begin
    awvalid   = '0;
    s_awready = 1'b0;
    bvalid    = 1'b0;
    bready    = 1'b0;
    w_done    = 1'b0;
    awburst   = 4'b1001;
    awlen     = 6'b101_011;
    awsize    = 6'b010_001;
    set_m(0, 5'd3, 32'h1000_0000);
    set_m(1, 5'd9, 32'h2000_0000);

    repeat (2) @(negedge clk);
    check("rst awvalid", 64'(s_awvalid), 64'd0);
    check("rst awready", 64'(awready), 64'd0);
    check("rst wvalid", 64'(w_mst_valid), 64'd0);
    check("rst wid", 64'(w_mst_id), 64'd0);
    check("rst outst", 64'(outst), 64'd0);
    check("rst awaddr", 64'(s_awaddr), 64'h1000_0000);
    check("rst awid", 64'(s_awid), 64'h03);
    rst_n = 1'b1;
    @(negedge clk);

    // single request from master 1
    set_m(1, 5'd5, 32'h4000_0010);
    awvalid   = 2'b10;
    s_awready = 1'b1;
    expect_aw(1);
    wait_aw("single", 1);
    awvalid = 2'b00;
    @(negedge clk);
    check("single awvalid_low", 64'(s_awvalid), 64'd0);
    check("single wvalid", 64'(w_mst_valid), 64'd1);
    check("single wid", 64'(w_mst_id), 64'd1);
    check("single outst", 64'(outst), 64'(exp_ctn));
    drain("single");

    // both masters requesting continuously: 0,1,0,1 every 2 cycles
    awvalid = 2'b11;
    expect_aw(0);
    expect_aw(1);
    expect_aw(0);
    expect_aw(1);
    wait_aw("rr0", 1);
    wait_aw("rr1", 2);
    wait_aw("rr2", 2);
    wait_aw("rr3", 2);
    awvalid = 2'b00;
    @(negedge clk);
    check("rr outst", 64'(outst), 64'd4);
    drain("rr");

    // slave stall with both masters pending
    awvalid   = 2'b11;
    s_awready = 1'b0;
    expect_aw(0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall awvalid", 64'(s_awvalid), 64'd1);
      check("stall awid", 64'(s_awid), 64'h03);
      check("stall awready", 64'(awready), 64'd0);
    end
    s_awready = 1'b1;
    #1;
    check("stall release awready", 64'(awready), 64'b01);
    check_hs("stall");
    awvalid = 2'b10;
    expect_aw(1);
    wait_aw("stall_next", 2);
    awvalid = 2'b00;
    @(negedge clk);
    drain("stall");

    // outstanding cap with no B responses
    awvalid = 2'b01;
    for (int k = 0; k < 8; k++) begin
      expect_aw(0);
      wait_aw("cap", (k == 0) ? 1 : 2);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("cap blocked awvalid", 64'(s_awvalid), 64'd0);
      check("cap outst", 64'(outst), 64'd8);
    end
    expect_aw(0);
    w_pop("cap unblock", 1'b1);
    wait_aw("cap ninth", 1);
    check("cap outst before simul", 64'(outst), 64'd7);
    awvalid = 2'b00;
    bvalid  = 1'b1;
    bready  = 1'b1;
    exp_ctn--;
    @(negedge clk);
    bvalid = 1'b0;
    bready = 1'b0;
    check("simul aw+b outst", 64'(outst), 64'd7);
    drain("cap");

    // B and w_done with nothing outstanding are ignored
    bvalid = 1'b1;
    bready = 1'b1;
    w_done = 1'b1;
    @(negedge clk);
    bvalid = 1'b0;
    bready = 1'b0;
    w_done = 1'b0;
    check("underflow outst", 64'(outst), 64'd0);
    check("underflow wvalid", 64'(w_mst_valid), 64'd0);

    // asynchronous reset while a grant is stalled
    awvalid = 2'b01;
    expect_aw(0);
    wait_aw("pre_rst", 1);
    @(posedge clk);
    #1 s_awready = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_rst awvalid", 64'(s_awvalid), 64'd1);
    check("pre_rst wvalid", 64'(w_mst_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async rst awvalid", 64'(s_awvalid), 64'd0);
    check("async rst outst", 64'(outst), 64'd0);
    check("async rst wvalid", 64'(w_mst_valid), 64'd0);
    check("async rst awready", 64'(awready), 64'd0);
    aw_q.delete();
    w_q.delete();
    exp_ctn = 0;
    awvalid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post rst outst", 64'(outst), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sa_aw_arbiter.md
# sa_aw_arbiter

Slave-side write-address arbiter. One instance per slave port of the interconnect. It shares the slave's AW channel among MST_AMT master dispatchers using round-robin arbitration, and tags each forwarded AWID with the winning master index. It records grant order for W-channel routing and caps write transactions outstanding at the slave.

## Interface
- MST_AMT, 2, number of requesting master dispatchers
- OUTSTANDING_AMT, 8, max AW accepted by the slave without a matching B handshake; also the order-FIFO depth
- OUTST_CTN_W, $clog2(OUTSTANDING_AMT)+1, outstanding counter width
- ADDR_WIDTH, 32; TRANS_MST_ID_W, 5; TRANS_BURST_W, 2; TRANS_DATA_LEN_W, 3; TRANS_DATA_SIZE_W, 3
- MST_ID_W, $clog2(MST_AMT), width of the master index
- TRANS_SLV_ID_W, TRANS_MST_ID_W+MST_ID_W, width of the slave-side AWID
- ACLK_i  in  1  clock, rising edge
- ARESETn_i  in  1  asynchronous active-low reset
- dsp_AWID_i  in  TRANS_MST_ID_W*MST_AMT  per-master AWID, packed with master 0 in the LSBs (same packing for all dsp_* buses)
- dsp_AWADDR_i  in  ADDR_WIDTH*MST_AMT
- dsp_AWBURST_i  in  TRANS_BURST_W*MST_AMT
- dsp_AWLEN_i  in  TRANS_DATA_LEN_W*MST_AMT
- dsp_AWSIZE_i  in  TRANS_DATA_SIZE_W*MST_AMT
- dsp_AWVALID_i  in  MST_AMT  per-master request
- dsp_AWREADY_o  out  MST_AMT  per-master accept
- s_AWID_o  out  TRANS_SLV_ID_W  {granted master index, master AWID}
- s_AWADDR_o, s_AWBURST_o, s_AWLEN_o, s_AWSIZE_o  out  matching widths  granted master's fields
- s_AWVALID_o  out  1;  s_AWREADY_i  in  1
- s_BVALID_i, s_BREADY_i  in  1  observed slave B handshake
- w_done_i  in  1  WLAST handshake completed at the slave
- w_mst_id_o  out  MST_ID_W  master owning the current W burst
- w_mst_valid_o  out  1  order FIFO non-empty
- outst_ctn_o  out  OUTST_CTN_W  current outstanding count

## Operation
- FSM with two states, IDLE and GRANT. Reset state is IDLE.
- IDLE:
  - blocked = (outst_ctn_o == OUTSTANDING_AMT) or order FIFO full.
  - If any dsp_AWVALID_i is set and the block is not blocked, latch grant = first requester at or after rr_ptr, scanning upward and wrapping past MST_AMT-1 to 0. Go to GRANT.
- GRANT:
  - s_AWVALID_o = 1.
  - s_AW* fields are driven by mux from the granted master; s_AWID_o = {grant, dsp_AWID[grant]}.
  - dsp_AWREADY_o[grant] = s_AWREADY_i; all other bits are 0.
  - On the handshake (s_AWVALID_o & s_AWREADY_i): rr_ptr <= grant+1 (wrapping), push grant into the order FIFO, increment the counter, go to IDLE.
  - The grant stays locked until the handshake completes, even if the master drops AWVALID. Dropping AWVALID is an AXI violation; no recovery logic is provided.
- Outstanding counter:
  - +1 on AW handshake, -1 on s_BVALID_i & s_BREADY_i.
  - Both in the same cycle: counter unchanged.
  - Decrement at 0 is ignored. It never exceeds OUTSTANDING_AMT.
- Order FIFO:
  - Push on AW handshake; pop on w_done_i.
  - w_mst_id_o = head entry; w_mst_valid_o = ~empty.
  - w_done_i while empty is ignored.
  - Push and pop in the same cycle are both honoured, including when the FIFO is full.

## Timing
- Reset values:
  - state = IDLE, rr_ptr = 0, outst_ctn_o = 0.
  - s_AWVALID_o = 0, dsp_AWREADY_o = 0, w_mst_valid_o = 0, w_mst_id_o = 0.
  - s_AW* payload = master 0's fields, since grant resets to 0.
- Reset mid-GRANT aborts the transfer immediately and flushes the order FIFO.
- Request at edge N → s_AWVALID_o high after edge N+1.
- s_AWREADY_i is combinationally forwarded to dsp_AWREADY_o. There is no registered path; AW latency is 1 cycle plus slave stall.
- Peak throughput is one AW per 2 cycles, because IDLE always separates grants.
- Unblocking from a B handshake at edge N allows a grant at edge N+1.
- A push at edge N makes w_mst_valid_o high after N; W can start in the cycle following the AW grant.

## Structure
- Shared package axi_ic_pkg holds the AXI width constants and the FSM state encoding (IDLE=1'b0, GRANT=1'b1).
- Sub-module: the existing codebase fifo, used as the order FIFO with DATA_WIDTH=MST_ID_W and FIFO_DEPTH=OUTSTANDING_AMT.
- The round-robin priority search is a generate loop inside this block. It is not a separate module.

## Test plan
- Single request: master 1 asserts AWVALID with AWID=5, AWADDR=0x4000_0010, and the slave holds AWREADY=1. Required: s_AWVALID_o rises one cycle later, s_AWID_o={1,5'd5}, the handshake completes, w_mst_id_o=1, outst_ctn_o=1.
- Round-robin: masters 0 and 1 both request continuously with the slave always ready. Required grant sequence 0,1,0,1, one AW every 2 cycles.
- Slave stall: the slave holds AWREADY=0 for 5 cycles. Required: s_AW* stays stable, dsp_AWREADY_o stays 0, and no other master is granted; accepted on cycle 6.
- Outstanding cap, with OUTSTANDING_AMT=8 and no B:
  - 8 AWs are accepted; a 9th request keeps s_AWVALID_o=0.
  - One B handshake → the 9th is granted on the next cycle.
  - Simultaneous AW and B handshakes leave the counter unchanged.
- W order: grant master 0, 1, 0, then pulse w_done_i three times. Required: w_mst_id_o reads 0, 1, 0, then w_mst_valid_o=0.
- Reset while in GRANT: assert ARESETn_i low asynchronously mid-cycle. Required: s_AWVALID_o, outst_ctn_o, and w_mst_valid_o go to 0 immediately, without waiting for a clock edge.
